// File: rtl/clk_div_pkg.sv
// Shared types and default parameters for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      MODE_PULSE  = 1'b0,
      MODE_SQUARE = 1'b1
   } mode_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV   = 4;

endpackage

// File: rtl/clk_div_cnt.sv
// Wrapping event counter: counts while enabled and returns to zero once it reaches div_q-1.
module clk_div_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] div_q,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // A shrunken divisor can leave the count above the new limit, so compare with >=.
   assign wrap = en && (cnt_q >= div_q - WIDTH'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/idle FSM, divisor and pending registers, error flag, output.
// Define CLK_DIV_SYNC_LD_EN to defer run-time divisor loads to the next wrap.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] div_in,
   input  logic             mode,
   output logic             fdclk,
   output logic [WIDTH-1:0] cnt,
   output logic             ld_pend,
   output logic             cfg_err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             ld_pend_q, ld_pend_d;
   logic             cfg_err_q, cfg_err_d;
   logic             fdclk_q, fdclk_d;
   logic             cnt_clr;
   logic             wrap;
   logic             ld_ok;
   logic             ld_bad;
   mode_t            mode_e;

   assign ld_ok  = ld && (div_in != '0);
   assign ld_bad = ld && (div_in == '0);
   assign mode_e = mode_t'(mode);

   clk_div_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .en    (en),
      .clr   (cnt_clr),
      .div_q (div_q),
      .cnt   (cnt),
      .wrap  (wrap)
   );

   always_comb begin
      state_d   = en ? RUN : IDLE;
      div_d     = div_q;
      pend_d    = pend_q;
      ld_pend_d = ld_pend_q;
      cfg_err_d = cfg_err_q;
      fdclk_d   = fdclk_q;
      cnt_clr   = 1'b0;
      if (clr) begin
         cnt_clr   = 1'b1;
         fdclk_d   = 1'b0;
         cfg_err_d = 1'b0;
         ld_pend_d = 1'b0;
         if (ld_ok) begin
            div_d = div_in;
         end else if (ld_pend_q) begin
            div_d = pend_q;
         end
      end else begin
         if (mode_e == MODE_PULSE) begin
            fdclk_d = wrap;
         end else begin
            fdclk_d = fdclk_q ^ wrap;
         end
         if (ld_bad) begin
            cfg_err_d = 1'b1;
         end
         // A fresh load in RUN wins over handing a previously pending divisor across the wrap.
         if (ld_ok && (state_q == IDLE)) begin
            div_d = div_in;
         end else if (ld_ok) begin
`ifdef CLK_DIV_SYNC_LD_EN
            pend_d    = div_in;
            ld_pend_d = 1'b1;
`else
            div_d   = div_in;
            cnt_clr = 1'b1;
`endif
         end else if (wrap && ld_pend_q) begin
            div_d     = pend_q;
            ld_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         div_q     <= WIDTH'(DEFAULT_DIV);
         pend_q    <= '0;
         ld_pend_q <= 1'b0;
         cfg_err_q <= 1'b0;
         fdclk_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pend_q    <= pend_d;
         ld_pend_q <= ld_pend_d;
         cfg_err_q <= cfg_err_d;
         fdclk_q   <= fdclk_d;
      end
   end

   assign fdclk   = fdclk_q;
   assign cfg_err = cfg_err_q;
`ifdef CLK_DIV_SYNC_LD_EN
   assign ld_pend = ld_pend_q;
`else
   assign ld_pend = 1'b0;
`endif

endmodule
